// File: rtl/tensor_core_matmul_engine.sv
// 4x4 signed matrix multiply: operands snapshotted on start, one result row per cycle,
// each element saturated to DATA_WIDTH, then a single bulk-write strobe.
//
// state     | meaning
// S_IDLE    | waiting for start_in; result_out holds last job
// S_COMPUTE | writing row r_row of result_out each cycle
// S_WRITE   | one-cycle bulk write strobe and done pulse
module tensor_core_matmul_engine #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                                 clock_in,
  input  logic                                 reset_in,
  input  logic                                 start_in,
  input  logic                                 abort_in,
  input  logic [3:0][3:0][DATA_WIDTH-1:0]      matrix_a_in,
  input  logic [3:0][3:0][DATA_WIDTH-1:0]      matrix_b_in,
  output logic [3:0][3:0][DATA_WIDTH-1:0]      result_out,
  output logic                                 result_write_enable_out,
  output logic                                 busy_out,
  output logic                                 done_out,
  output logic                                 saturated_out
);

  localparam int ACC_W = 2*DATA_WIDTH + 2;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< (DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_WRITE} state_t;

  state_t                            r_state;
  state_t                            w_state_nxt;
  logic [1:0]                        r_row;
  logic [3:0][3:0][DATA_WIDTH-1:0]   r_a;
  logic [3:0][3:0][DATA_WIDTH-1:0]   r_b;
  logic [3:0][3:0][DATA_WIDTH-1:0]   r_result;
  logic                              r_sat;
  logic                              w_accept;
  logic                              w_row_wr;
  logic [3:0][DATA_WIDTH-1:0]        w_sat_row;
  logic                              w_clip;
  logic signed [ACC_W-1:0]           w_acc;

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Restart from WRITE keeps back-to-back throughput at one job per five cycles.
  always_comb begin
    w_state_nxt             = r_state;
    w_accept                = 1'b0;
    w_row_wr                = 1'b0;
    busy_out                = 1'b0;
    result_write_enable_out = 1'b0;
    done_out                = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_in && !abort_in) begin
          w_accept    = 1'b1;
          w_state_nxt = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        busy_out = 1'b1;
        if (abort_in) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_row_wr = 1'b1;
          if (r_row == 2'd3) w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        busy_out                = 1'b1;
        result_write_enable_out = 1'b1;
        done_out                = 1'b1;
        if (start_in && !abort_in) begin
          w_accept    = 1'b1;
          w_state_nxt = S_COMPUTE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_sat_row = '0;
    w_clip    = 1'b0;
    w_acc     = '0;
    for (int j = 0; j < 4; j++) begin
      w_acc = '0;
      for (int k = 0; k < 4; k++) begin
        w_acc = w_acc + ACC_W'($signed(r_a[r_row][k])) * ACC_W'($signed(r_b[k][j]));
      end
      if (w_acc > SAT_MAX) begin
        w_sat_row[j] = SAT_MAX[DATA_WIDTH-1:0];
        w_clip       = 1'b1;
      end else if (w_acc < SAT_MIN) begin
        w_sat_row[j] = SAT_MIN[DATA_WIDTH-1:0];
        w_clip       = 1'b1;
      end else begin
        w_sat_row[j] = w_acc[DATA_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_sat    <= 1'b0;
      r_row    <= 2'd0;
    end else if (w_accept) begin
      r_a   <= matrix_a_in;
      r_b   <= matrix_b_in;
      r_sat <= 1'b0;
      r_row <= 2'd0;
    end else if (w_row_wr) begin
      r_result[r_row] <= w_sat_row;
      r_row           <= r_row + 2'd1;
      if (w_clip) r_sat <= 1'b1;
    end
  end

  assign result_out    = r_result;
  assign saturated_out = r_sat;

endmodule

// File: tb/tb_tensor_core_matmul_engine.sv
// Directed bench for tensor_core_matmul_engine: latency, saturation, snapshot,
// abort, mid-job reset and back-to-back jobs against hand-computed matrices.
module tb_tensor_core_matmul_engine;

  typedef logic [3:0][3:0][3:0] mat_t;

  logic clock_in = 1'b0;
  logic reset_in = 1'b1;
  logic start_in = 1'b0;
  logic abort_in = 1'b0;
  mat_t matrix_a_in = '0;
  mat_t matrix_b_in = '0;
  mat_t result_out;
  logic result_write_enable_out;
  logic busy_out;
  logic done_out;
  logic saturated_out;

  int errors = 0;
  int checks = 0;

  tensor_core_matmul_engine #(.DATA_WIDTH(4)) dut (
    .clock_in                (clock_in),
    .reset_in                (reset_in),
    .start_in                (start_in),
    .abort_in                (abort_in),
    .matrix_a_in             (matrix_a_in),
    .matrix_b_in             (matrix_b_in),
    .result_out              (result_out),
    .result_write_enable_out (result_write_enable_out),
    .busy_out                (busy_out),
    .done_out                (done_out),
    .saturated_out           (saturated_out)
  );

  always #5 clock_in = ~clock_in;

  function automatic mat_t fill(input logic [3:0] v);
    mat_t m;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) m[i][j] = v;
    return m;
  endfunction

  function automatic mat_t ident();
    mat_t m;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) m[i][j] = (i == j) ? 4'd1 : 4'd0;
    return m;
  endfunction

  // B[i][j] = i - j, values -3..3
  function automatic mat_t bpat();
    mat_t m;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) m[i][j] = 4'(i - j);
    return m;
  endfunction

  // Leaves the bench just after the start edge, i.e. inside cycle 1.
  task automatic start_job(input mat_t a, input mat_t b);
    @(negedge clock_in);
    start_in    = 1'b1;
    matrix_a_in = a;
    matrix_b_in = b;
    @(posedge clock_in);
    #1;
    start_in = 1'b0;
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    #1 reset_in = 1'b0;
    #1;
    checks++;
    if (result_out !== '0) begin errors++; $display("FAIL reset_result got %h expected 0", result_out); end
    checks++;
    if ({busy_out, result_write_enable_out, done_out, saturated_out} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got busy/we/done/sat=%b expected 0000",
               {busy_out, result_write_enable_out, done_out, saturated_out});
    end
    @(negedge clock_in);
    reset_in = 1'b1;
  endtask

  task automatic test_identity();
    mat_t exp_b;
    exp_b = bpat();
    start_job(ident(), exp_b);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock_in);
      checks++;
      if (busy_out !== 1'b1) begin errors++; $display("FAIL ident_busy cycle %0d got %b expected 1", c, busy_out); end
      checks++;
      if (result_write_enable_out !== (c == 5)) begin
        errors++; $display("FAIL ident_strobe cycle %0d got %b expected %b", c, result_write_enable_out, (c == 5));
      end
      checks++;
      if (done_out !== (c == 5)) begin
        errors++; $display("FAIL ident_done cycle %0d got %b expected %b", c, done_out, (c == 5));
      end
    end
    checks++;
    if (result_out !== exp_b) begin errors++; $display("FAIL ident_result got %h expected %h", result_out, exp_b); end
    checks++;
    if (saturated_out !== 1'b0) begin errors++; $display("FAIL ident_sat got %b expected 0", saturated_out); end
    @(negedge clock_in);
    checks++;
    if ({busy_out, result_write_enable_out} !== 2'b00) begin
      errors++; $display("FAIL ident_idle got busy/we=%b expected 00", {busy_out, result_write_enable_out});
    end
    @(negedge clock_in);
    checks++;
    if (result_out !== exp_b) begin errors++; $display("FAIL ident_hold got %h expected %h", result_out, exp_b); end
  endtask

  task automatic test_saturation();
    start_job(fill(4'd7), fill(4'd7));
    repeat (5) @(negedge clock_in);
    checks++;
    if (result_write_enable_out !== 1'b1) begin errors++; $display("FAIL satpos_strobe got %b expected 1", result_write_enable_out); end
    checks++;
    if (result_out !== fill(4'd7)) begin errors++; $display("FAIL satpos_result got %h expected %h", result_out, fill(4'd7)); end
    checks++;
    if (saturated_out !== 1'b1) begin errors++; $display("FAIL satpos_flag got %b expected 1", saturated_out); end
    @(negedge clock_in);
    checks++;
    if (saturated_out !== 1'b1) begin errors++; $display("FAIL sat_sticky got %b expected 1", saturated_out); end
    start_job(fill(4'h8), fill(4'd7));
    checks++;
    if (saturated_out !== 1'b0) begin errors++; $display("FAIL sat_clear_on_start got %b expected 0", saturated_out); end
    repeat (5) @(negedge clock_in);
    checks++;
    if (result_out !== fill(4'h8)) begin errors++; $display("FAIL satneg_result got %h expected %h", result_out, fill(4'h8)); end
    checks++;
    if (saturated_out !== 1'b1) begin errors++; $display("FAIL satneg_flag got %b expected 1", saturated_out); end
  endtask

  task automatic test_snapshot();
    start_job(fill(4'd1), fill(4'd1));
    @(negedge clock_in);
    @(negedge clock_in);
    matrix_a_in = fill(4'd7);
    matrix_b_in = fill(4'd7);
    start_in    = 1'b1;
    @(posedge clock_in);
    #1 start_in = 1'b0;
    repeat (3) @(negedge clock_in);
    checks++;
    if (result_write_enable_out !== 1'b1) begin errors++; $display("FAIL snap_strobe got %b expected 1", result_write_enable_out); end
    checks++;
    if (result_out !== fill(4'd4)) begin errors++; $display("FAIL snap_result got %h expected %h", result_out, fill(4'd4)); end
    checks++;
    if (saturated_out !== 1'b0) begin errors++; $display("FAIL snap_sat got %b expected 0", saturated_out); end
    for (int c = 6; c <= 10; c++) begin
      @(negedge clock_in);
      checks++;
      if (busy_out !== 1'b0) begin errors++; $display("FAIL snap_no_second_job cycle %0d got busy %b expected 0", c, busy_out); end
    end
  endtask

  task automatic test_abort();
    mat_t bp;
    mat_t exp_r;
    bp    = bpat();
    exp_r = fill(4'd4);
    exp_r[0] = bp[0];
    exp_r[1] = bp[1];
    start_job(ident(), bp);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock_in);
      checks++;
      if (result_write_enable_out !== 1'b0) begin errors++; $display("FAIL abort_strobe cycle %0d got %b expected 0", c, result_write_enable_out); end
    end
    abort_in = 1'b1;
    @(posedge clock_in);
    #1 abort_in = 1'b0;
    for (int c = 4; c <= 6; c++) begin
      @(negedge clock_in);
      checks++;
      if ({busy_out, result_write_enable_out, done_out} !== 3'b000) begin
        errors++; $display("FAIL abort_idle cycle %0d got busy/we/done=%b expected 000", c,
                           {busy_out, result_write_enable_out, done_out});
      end
    end
    checks++;
    if (result_out !== exp_r) begin errors++; $display("FAIL abort_rows got %h expected %h", result_out, exp_r); end
    @(negedge clock_in);
    start_in = 1'b1;
    abort_in = 1'b1;
    @(posedge clock_in);
    #1;
    start_in = 1'b0;
    abort_in = 1'b0;
    @(negedge clock_in);
    checks++;
    if (busy_out !== 1'b0) begin errors++; $display("FAIL abort_priority_idle got busy %b expected 0", busy_out); end
  endtask

  task automatic test_reset_mid();
    start_job(fill(4'd7), fill(4'd7));
    @(negedge clock_in);
    @(negedge clock_in);
    #2 reset_in = 1'b0;
    #1;
    checks++;
    if (result_out !== '0) begin errors++; $display("FAIL midrst_result got %h expected 0", result_out); end
    checks++;
    if ({busy_out, result_write_enable_out, done_out, saturated_out} !== 4'b0000) begin
      errors++; $display("FAIL midrst_flags got busy/we/done/sat=%b expected 0000",
                         {busy_out, result_write_enable_out, done_out, saturated_out});
    end
    @(negedge clock_in);
    reset_in = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock_in);
      checks++;
      if ({busy_out, result_write_enable_out} !== 2'b00) begin
        errors++; $display("FAIL midrst_no_strobe step %0d got busy/we=%b expected 00", c, {busy_out, result_write_enable_out});
      end
    end
    // 1*2 summed four times = 8, one above the positive limit
    start_job(fill(4'd1), fill(4'd2));
    repeat (5) @(negedge clock_in);
    checks++;
    if (result_write_enable_out !== 1'b1) begin errors++; $display("FAIL midrst_newjob_strobe got %b expected 1", result_write_enable_out); end
    checks++;
    if (result_out !== fill(4'd7)) begin errors++; $display("FAIL midrst_newjob_result got %h expected %h", result_out, fill(4'd7)); end
    checks++;
    if (saturated_out !== 1'b1) begin errors++; $display("FAIL midrst_newjob_sat got %b expected 1", saturated_out); end
  endtask

  task automatic test_back_to_back();
    mat_t bp;
    bp = bpat();
    @(negedge clock_in);
    start_in    = 1'b1;
    matrix_a_in = ident();
    matrix_b_in = bp;
    @(posedge clock_in);
    #1;
    matrix_a_in = fill(4'd2);
    matrix_b_in = fill(4'hF);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock_in);
      checks++;
      if (busy_out !== 1'b1) begin errors++; $display("FAIL b2b_busy cycle %0d got %b expected 1", c, busy_out); end
      checks++;
      if (result_write_enable_out !== (c == 5 || c == 10)) begin
        errors++; $display("FAIL b2b_strobe cycle %0d got %b expected %b", c, result_write_enable_out, (c == 5 || c == 10));
      end
      if (c == 5) begin
        checks++;
        if (result_out !== bp) begin errors++; $display("FAIL b2b_job1_result got %h expected %h", result_out, bp); end
      end
      if (c == 6) start_in = 1'b0;
      if (c == 10) begin
        checks++;
        if (result_out !== fill(4'h8)) begin errors++; $display("FAIL b2b_job2_result got %h expected %h", result_out, fill(4'h8)); end
        checks++;
        if (saturated_out !== 1'b0) begin errors++; $display("FAIL b2b_job2_sat got %b expected 0", saturated_out); end
      end
    end
    @(negedge clock_in);
    checks++;
    if (busy_out !== 1'b0) begin errors++; $display("FAIL b2b_end_idle got busy %b expected 0", busy_out); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_saturation();
    test_snapshot();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
